// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two requesters, the single-port memory and the arbiter.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface mem_arbiter_if;
  logic       A_REQ;
  logic       A_WE;
  logic       A_LOCK;
  logic [7:0] A_ADDR;
  logic [7:0] A_WDATA;
  logic       A_GNT;
  logic       A_RVALID;
  logic [7:0] A_RDATA;

  logic       B_REQ;
  logic       B_WE;
  logic       B_LOCK;
  logic [7:0] B_ADDR;
  logic [7:0] B_WDATA;
  logic       B_GNT;
  logic       B_RVALID;
  logic [7:0] B_RDATA;

  logic       MEM_EN;
  logic       MEM_WE;
  logic [7:0] MEM_ADDR;
  logic [7:0] MEM_WDATA;
  logic [7:0] MEM_RDATA;

  logic       BUSY;

  modport slave (
    input  A_REQ, A_WE, A_LOCK, A_ADDR, A_WDATA,
    output A_GNT, A_RVALID, A_RDATA,
    input  B_REQ, B_WE, B_LOCK, B_ADDR, B_WDATA,
    output B_GNT, B_RVALID, B_RDATA,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA,
    output BUSY
  );

  modport master (
    output A_REQ, A_WE, A_LOCK, A_ADDR, A_WDATA,
    input  A_GNT, A_RVALID, A_RDATA,
    output B_REQ, B_WE, B_LOCK, B_ADDR, B_WDATA,
    input  B_GNT, B_RVALID, B_RDATA,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA,
    input  BUSY
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: round-robin when idle, bounded
// ownership locking under contention, one-cycle read-data return per requester.
module mem_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(MAX_LOCK);
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             gnt_a, gnt_b;
  logic             a_rvalid, b_rvalid;

  assign lock_cnt_inc = (lock_cnt == CNT_SAT) ? lock_cnt : lock_cnt + CNT_W'(1);

  // State, pointer, lock counter and read-valid registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last     <= LAST_B;
      lock_cnt <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
      a_rvalid <= gnt_a & ~bus.A_WE;
      b_rvalid <= gnt_b & ~bus.B_WE;
    end
  end

  // Grant selection and next-state
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    lock_cnt_nxt = lock_cnt;
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.A_REQ && (!bus.B_REQ || last == LAST_B)) gnt_a = 1'b1;
        else if (bus.B_REQ)                               gnt_b = 1'b1;
      end
      OWN_A: begin
        // Owner loses its slot only once it has used its quota and B is waiting
        if (bus.A_REQ && !(bus.B_REQ && lock_cnt >= LOCK_LIM)) gnt_a = 1'b1;
        else if (bus.B_REQ)                                     gnt_b = 1'b1;
      end
      OWN_B: begin
        if (bus.B_REQ && !(bus.A_REQ && lock_cnt >= LOCK_LIM)) gnt_b = 1'b1;
        else if (bus.A_REQ)                                     gnt_a = 1'b1;
      end
      default: ;
    endcase

    if (RST) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end

    // A grant taken from the other owner's dropped request returns to IDLE;
    // one taken by forfeit (other still requesting) may start a new ownership.
    if (gnt_a) begin
      last_nxt = LAST_A;
      if (bus.A_LOCK && (state != OWN_B || bus.B_REQ)) begin
        state_nxt    = OWN_A;
        lock_cnt_nxt = (state == OWN_A) ? lock_cnt_inc : CNT_W'(1);
      end else begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    end else if (gnt_b) begin
      last_nxt = LAST_B;
      if (bus.B_LOCK && (state != OWN_A || bus.A_REQ)) begin
        state_nxt    = OWN_B;
        lock_cnt_nxt = (state == OWN_B) ? lock_cnt_inc : CNT_W'(1);
      end else begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    end else begin
      state_nxt    = IDLE;
      lock_cnt_nxt = '0;
    end
  end

  assign bus.A_GNT = gnt_a;
  assign bus.B_GNT = gnt_b;

  // Memory port carries the granted requester's access, quiet otherwise
  assign bus.MEM_EN    = gnt_a | gnt_b;
  assign bus.MEM_WE    = gnt_a ? bus.A_WE    : (gnt_b ? bus.B_WE    : 1'b0);
  assign bus.MEM_ADDR  = gnt_a ? bus.A_ADDR  : (gnt_b ? bus.B_ADDR  : 8'h00);
  assign bus.MEM_WDATA = gnt_a ? bus.A_WDATA : (gnt_b ? bus.B_WDATA : 8'h00);

  assign bus.A_RVALID = a_rvalid;
  assign bus.B_RVALID = b_rvalid;
  assign bus.A_RDATA  = a_rvalid ? bus.MEM_RDATA : 8'h00;
  assign bus.B_RDATA  = b_rvalid ? bus.MEM_RDATA : 8'h00;

  assign bus.BUSY = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 memory (initial content addr ^ 8'h5A).
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_LOCK(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.MEM_EN) begin
      if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
      else            bus.MEM_RDATA     <= mem[bus.MEM_ADDR];
    end
  end

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic ea, input logic eb, input logic busy);
    chk({tag, "_a_gnt"}, 8'(bus.A_GNT), 8'(ea));
    chk({tag, "_b_gnt"}, 8'(bus.B_GNT), 8'(eb));
    chk({tag, "_mem_en"}, 8'(bus.MEM_EN), 8'(ea | eb));
    chk({tag, "_busy"}, 8'(bus.BUSY), 8'(busy));
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] wdata);
    bus.A_REQ = req; bus.A_WE = we; bus.A_LOCK = lock; bus.A_ADDR = addr; bus.A_WDATA = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] wdata);
    bus.B_REQ = req; bus.B_WE = we; bus.B_LOCK = lock; bus.B_ADDR = addr; bus.B_WDATA = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] exp_a32;
  logic [6:0] exp_busy32;

  initial begin
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) next_cycle();

    // Requests present while reset is held: no grant, no memory activity
    set_a(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
    @(negedge clk);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_mem_we", 8'(bus.MEM_WE), 8'h00);
    chk("rst_a_rvalid", 8'(bus.A_RVALID), 8'h00);
    chk("rst_b_rvalid", 8'(bus.B_RVALID), 8'h00);
    next_cycle();
    rst = 1'b0;

    // Contested reads alternate starting with A
    @(negedge clk);
    chk_ctl("rr_c1", 1'b1, 1'b0, 1'b0);
    chk("rr_c1_addr", bus.MEM_ADDR, 8'h02);
    chk("rr_c1_a_rdata_idle", bus.A_RDATA, 8'h00);
    next_cycle();
    @(negedge clk);
    chk_ctl("rr_c2", 1'b0, 1'b1, 1'b0);
    chk("rr_c2_addr", bus.MEM_ADDR, 8'h03);
    chk("rr_c2_a_rvalid", 8'(bus.A_RVALID), 8'h01);
    chk("rr_c2_a_rdata", bus.A_RDATA, 8'h58);
    next_cycle();
    @(negedge clk);
    chk_ctl("rr_c3", 1'b1, 1'b0, 1'b0);
    chk("rr_c3_a_rvalid", 8'(bus.A_RVALID), 8'h00);
    chk("rr_c3_b_rvalid", 8'(bus.B_RVALID), 8'h01);
    chk("rr_c3_b_rdata", bus.B_RDATA, 8'h59);
    next_cycle();
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_ctl("rr_c4", 1'b0, 1'b0, 1'b0);
    chk("rr_c4_a_rdata", bus.A_RDATA, 8'h58);
    chk("rr_c4_b_rvalid", 8'(bus.B_RVALID), 8'h00);
    next_cycle();

    // B writes 0x0C to 0x10, A reads it back
    set_b(1'b1, 1'b1, 1'b0, 8'h10, 8'h0C);
    @(negedge clk);
    chk_ctl("wr_b", 1'b0, 1'b1, 1'b0);
    chk("wr_b_mem_we", 8'(bus.MEM_WE), 8'h01);
    chk("wr_b_wdata", bus.MEM_WDATA, 8'h0C);
    chk("wr_b_addr", bus.MEM_ADDR, 8'h10);
    next_cycle();
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk_ctl("rd_a", 1'b1, 1'b0, 1'b0);
    chk("rd_a_mem_we", 8'(bus.MEM_WE), 8'h00);
    chk("wr_b_no_rvalid", 8'(bus.B_RVALID), 8'h00);
    next_cycle();
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd_a_rvalid", 8'(bus.A_RVALID), 8'h01);
    chk("rd_a_rdata", bus.A_RDATA, 8'h0C);
    next_cycle();

    // Lock bound: B locked against continuously requesting A
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_a(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    set_b(1'b1, 1'b0, 1'b1, 8'h04, 8'h00);
    exp_a32    = 7'b0100001;
    exp_busy32 = 7'b0111100;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("lock_b_c%0d", i + 1), exp_a32[i], ~exp_a32[i], exp_busy32[i]);
      next_cycle();
    end
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_ctl("own_b_drop", 1'b0, 1'b0, 1'b1);
    next_cycle();

    // Uncontested A lock burst runs past MAX_LOCK and past counter saturation
    set_a(1'b1, 1'b0, 1'b1, 8'h05, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk_ctl($sformatf("burst_a_c%0d", k), 1'b1, 1'b0, k >= 2);
      if (k >= 2) chk($sformatf("burst_a_rdata_c%0d", k), bus.A_RDATA, 8'h5F);
      next_cycle();
    end

    // Contention after saturation forces the slot to B
    set_b(1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
    @(negedge clk);
    chk_ctl("forfeit_b", 1'b0, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_ctl("forfeit_a_back", 1'b1, 1'b0, 1'b0);
    chk("forfeit_b_rdata", bus.B_RDATA, 8'h5C);
    next_cycle();
    @(negedge clk);
    chk_ctl("own_a_read", 1'b1, 1'b0, 1'b1);
    next_cycle();

    // Reset while A owns the memory with a read in flight
    rst = 1'b1;
    @(negedge clk);
    chk_ctl("rst_lock_c1", 1'b0, 1'b0, 1'b1);
    chk("rst_lock_c1_mem_we", 8'(bus.MEM_WE), 8'h00);
    next_cycle();
    @(negedge clk);
    chk_ctl("rst_lock_c2", 1'b0, 1'b0, 1'b0);
    chk("rst_lock_a_rvalid", 8'(bus.A_RVALID), 8'h00);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_ctl("rst_release", 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Quiet bus
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("quiet_c%0d", i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("quiet_c%0d_a_rvalid", i), 8'(bus.A_RVALID), 8'h00);
      chk($sformatf("quiet_c%0d_b_rvalid", i), 8'(bus.B_RVALID), 8'h00);
      chk($sformatf("quiet_c%0d_addr", i), bus.MEM_ADDR, 8'h00);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
